// File: rtl/rule_compactor.sv
// rule_compactor
//   Packs a sparse stream of 16-bit rule IDs (0 = no match) into dense
//   eight-lane beats. Surviving IDs keep arrival order, and packet framing is
//   preserved.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_usr_data/valid/ready       input beats (LANES x 16-bit lanes, lane 0 first)
//   in_usr_sop/eop/empty          input framing; empty bytes mask the top lanes
//   out_usr_data/valid/ready      packed output beats (unused lanes are 0)
//   out_usr_sop/eop/empty         output framing; empty = 2*(8-n) for n lanes
//   rule_cnt                      nonzero rule IDs handed downstream (wraps)
//   pkt_cnt                       eop beats handed downstream (wraps)
module rule_compactor #(
    parameter int LANES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LANES*16-1:0]   in_usr_data,
    input  logic                  in_usr_valid,
    output logic                  in_usr_ready,
    input  logic                  in_usr_sop,
    input  logic                  in_usr_eop,
    input  logic [3:0]            in_usr_empty,
    output logic [LANES*16-1:0]   out_usr_data,
    output logic                  out_usr_valid,
    input  logic                  out_usr_ready,
    output logic                  out_usr_sop,
    output logic                  out_usr_eop,
    output logic [3:0]            out_usr_empty,
    output logic [31:0]           rule_cnt,
    output logic [31:0]           pkt_cnt
);
    localparam int LW = 16;
    localparam int DW = LANES * LW;          // one beat
    localparam int AW = (LANES - 1) * LW;    // accumulator
    localparam int CW = DW + AW;             // accumulator + incoming beat

    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [3:0]      acc_cnt_q, acc_cnt_d;
    logic            sop_pend_q, sop_pend_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_sop_q, out_sop_d;
    logic            out_eop_q, out_eop_d;
    logic [3:0]      out_empty_q, out_empty_d;
    logic [31:0]     rule_cnt_q, rule_cnt_d;
    logic [31:0]     pkt_cnt_q, pkt_cnt_d;

    logic [4:0]      lane_lim;
    logic [DW-1:0]   comp_vec;
    logic [3:0]      k;
    logic [3:0]      base;
    logic [AW-1:0]   acc_eff;
    logic [CW-1:0]   cat_vec;
    logic [4:0]      t;
    logic [3:0]      out_nz;
    logic            load_ok;
    logic            accept;

    function automatic logic [3:0] empty_of(input logic [4:0] n);
        return 4'(5'd16 - {n[3:0], 1'b0});
    endfunction

    // Lanes at or above the empty boundary are treated as zero.
    assign lane_lim = (5'd16 - {1'b0, in_usr_empty}) >> 1;

    // Prefix-popcount compaction: each surviving lane lands at the count of
    // survivors before it.
    always_comb begin
        comp_vec = '0;
        k        = '0;
        for (int i = 0; i < LANES; i++) begin
            if (5'(i) < lane_lim && in_usr_data[i*LW +: LW] != '0) begin
                comp_vec[k[2:0]*LW +: LW] = in_usr_data[i*LW +: LW];
                k = k + 4'd1;
            end
        end
    end

    // An input sop discards any leftover lanes of a malformed prior packet.
    // Accumulator lanes above acc_cnt are always zero, so a shift-and-OR
    // appends the compacted beat after the held lanes.
    assign base    = in_usr_sop ? 4'd0 : acc_cnt_q;
    assign acc_eff = in_usr_sop ? '0 : acc_q;
    assign cat_vec = ({{AW{1'b0}}, comp_vec} << {base, 4'b0000}) | {{DW{1'b0}}, acc_eff};
    assign t       = {1'b0, base} + {1'b0, k};

    always_comb begin
        out_nz = '0;
        for (int i = 0; i < LANES; i++) begin
            if (out_data_q[i*LW +: LW] != '0) out_nz = out_nz + 4'd1;
        end
    end

    assign load_ok      = !out_valid_q || out_usr_ready;
    assign in_usr_ready = rst_n && (state_q == RUN) && load_ok;
    assign accept       = in_usr_valid && in_usr_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        sop_pend_d  = sop_pend_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_empty_d = out_empty_q;
        rule_cnt_d  = rule_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;

        if (out_valid_q && out_usr_ready) begin
            out_valid_d = 1'b0;
            rule_cnt_d  = rule_cnt_q + 32'(out_nz);
            if (out_eop_q) pkt_cnt_d = pkt_cnt_q + 32'd1;
        end

        case (state_q)
            RUN: begin
                if (accept) begin
                    if (!in_usr_eop && t < 5'd8) begin
                        acc_d     = cat_vec[AW-1:0];
                        acc_cnt_d = t[3:0];
                    end else if (t > 5'd8 || (!in_usr_eop && t == 5'd8)) begin
                        // Full beat; any leftover lanes stay in the accumulator.
                        out_valid_d = 1'b1;
                        out_data_d  = cat_vec[DW-1:0];
                        out_sop_d   = sop_pend_q;
                        out_eop_d   = 1'b0;
                        out_empty_d = 4'd0;
                        sop_pend_d  = 1'b0;
                        acc_d       = cat_vec[DW +: AW];
                        acc_cnt_d   = 4'(t - 5'd8);
                        if (in_usr_eop) state_d = FLUSH;
                    end else begin
                        // Closing beat of the packet; t == 0 yields the all-zero marker.
                        out_valid_d = 1'b1;
                        out_data_d  = cat_vec[DW-1:0];
                        out_sop_d   = sop_pend_q;
                        out_eop_d   = 1'b1;
                        out_empty_d = (t == 5'd0) ? 4'd14 : empty_of(t);
                        sop_pend_d  = 1'b1;
                        acc_d       = '0;
                        acc_cnt_d   = 4'd0;
                    end
                end
            end
            FLUSH: begin
                if (load_ok) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {{LW{1'b0}}, acc_q};
                    out_sop_d   = 1'b0;
                    out_eop_d   = 1'b1;
                    out_empty_d = empty_of({1'b0, acc_cnt_q});
                    sop_pend_d  = 1'b1;
                    acc_d       = '0;
                    acc_cnt_d   = 4'd0;
                    state_d     = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            sop_pend_q  <= 1'b1;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= '0;
            rule_cnt_q  <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            sop_pend_q  <= sop_pend_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_empty_q <= out_empty_d;
            rule_cnt_q  <= rule_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign out_usr_data  = out_data_q;
    assign out_usr_valid = out_valid_q;
    assign out_usr_sop   = out_sop_q;
    assign out_usr_eop   = out_eop_q;
    assign out_usr_empty = out_empty_q;
    assign rule_cnt      = rule_cnt_q;
    assign pkt_cnt       = pkt_cnt_q;

endmodule
